// File: rtl/pong_score_keeper.sv
// Two-player BCD score keeper for Pong: point edge detection, serve delay, game-over and winner.
// Optional winner blink on digit_blank is enabled by defining SCORE_WIN_BLINK_EN.
module pong_score_keeper #(
  parameter int unsigned WIN_SCORE    = 11,
  parameter int unsigned SERVE_DELAY  = 50_000_000,
  parameter int unsigned BLINK_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       new_game,
  input  logic       point_p1,
  input  logic       point_p2,
  output logic [3:0] p1_tens,
  output logic [3:0] p1_ones,
  output logic [3:0] p2_tens,
  output logic [3:0] p2_ones,
  output logic       serve,
  output logic       serve_dir,
  output logic       game_over,
  output logic       winner,
  output logic [3:0] digit_blank
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SERVE_WAIT = 2'd1,
    PLAY       = 2'd2,
    GAME_OVER  = 2'd3
  } state_e;

  // One down-counter serves both the serve delay and the winner blink period.
  localparam int unsigned CNT_MAX = (SERVE_DELAY > BLINK_CYCLES) ? SERVE_DELAY : BLINK_CYCLES;
  localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] SERVE_LOAD = CNT_W'(SERVE_DELAY - 1);
`ifdef SCORE_WIN_BLINK_EN
  localparam logic [CNT_W-1:0] BLINK_LOAD = CNT_W'(BLINK_CYCLES - 1);
`endif

  function automatic logic [7:0] bcd_inc(input logic [7:0] s);
    logic [7:0] r;
    if (s[3:0] == 4'd9) begin
      r = {s[7:4] + 4'd1, 4'd0};
    end else begin
      r = {s[7:4], s[3:0] + 4'd1};
    end
    return r;
  endfunction

  function automatic logic [6:0] bcd_val(input logic [7:0] s);
    return (7'(s[7:4]) * 7'd10) + 7'(s[3:0]);
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             new_game_q, p1_q, p2_q;
  logic [7:0]       p1_score_q, p1_score_d, p2_score_q, p2_score_d;
  logic             serve_q, serve_d;
  logic             serve_dir_q, serve_dir_d;
  logic             game_over_q, game_over_d;
  logic             winner_q, winner_d;
  logic             ng_ev_s, p1_ev_s, p2_ev_s, score_ev_s, win_s;
  logic [7:0]       p1_inc_s, p2_inc_s;
`ifdef SCORE_WIN_BLINK_EN
  logic             phase_q, phase_d;
  logic [3:0]       digit_blank_q, digit_blank_d;
`endif

  assign ng_ev_s    = new_game & ~new_game_q;
  assign p1_ev_s    = point_p1 & ~p1_q;
  assign p2_ev_s    = point_p2 & ~p2_q;
  assign score_ev_s = (state_q == PLAY) && !ng_ev_s && (p1_ev_s ^ p2_ev_s);
  assign p1_inc_s   = bcd_inc(p1_score_q);
  assign p2_inc_s   = bcd_inc(p2_score_q);
  assign win_s      = p1_ev_s ? (bcd_val(p1_inc_s) == 7'(WIN_SCORE))
                              : (bcd_val(p2_inc_s) == 7'(WIN_SCORE));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a new_game edge overrides everything, including a coincident point.
  always_comb begin
    state_d = state_q;
    if (ng_ev_s) begin
      state_d = SERVE_WAIT;
    end else begin
      case (state_q)
        IDLE:       state_d = IDLE;
        SERVE_WAIT: state_d = (cnt_q == '0) ? PLAY : SERVE_WAIT;
        PLAY: begin
          if (p1_ev_s ^ p2_ev_s) begin
            state_d = win_s ? GAME_OVER : SERVE_WAIT;
          end else begin
            state_d = PLAY;
          end
        end
        GAME_OVER:  state_d = GAME_OVER;
        default:    state_d = IDLE;
      endcase
    end
  end

  // Output and datapath next values.
  always_comb begin
    p1_score_d  = p1_score_q;
    p2_score_d  = p2_score_q;
    serve_dir_d = serve_dir_q;
    winner_d    = winner_q;
    cnt_d       = '0;
`ifdef SCORE_WIN_BLINK_EN
    phase_d       = 1'b0;
    digit_blank_d = 4'b0000;
`endif
    if (ng_ev_s) begin
      p1_score_d  = 8'h00;
      p2_score_d  = 8'h00;
      serve_dir_d = 1'b0;
      winner_d    = 1'b0;
    end else if (score_ev_s) begin
      if (p1_ev_s) begin
        p1_score_d = p1_inc_s;
      end else begin
        p2_score_d = p2_inc_s;
      end
      serve_dir_d = p1_ev_s;
      winner_d    = win_s ? p2_ev_s : winner_q;
    end else begin
      serve_dir_d = serve_dir_q;
    end

    case (state_d)
      SERVE_WAIT: begin
        if ((state_q == SERVE_WAIT) && !ng_ev_s) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          cnt_d = SERVE_LOAD;
        end
      end
      GAME_OVER: begin
`ifdef SCORE_WIN_BLINK_EN
        if (state_q != GAME_OVER) begin
          cnt_d   = BLINK_LOAD;
          phase_d = 1'b0;
        end else if (cnt_q == '0) begin
          cnt_d   = BLINK_LOAD;
          phase_d = ~phase_q;
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
          phase_d = phase_q;
        end
        digit_blank_d = phase_d ? (winner_d ? 4'b0011 : 4'b1100) : 4'b0000;
`else
        cnt_d = '0;
`endif
      end
      default: cnt_d = '0;
    endcase

    serve_d     = (state_q == SERVE_WAIT) && !ng_ev_s && (cnt_q == '0);
    game_over_d = (state_d == GAME_OVER);
  end

  // Edge-detect, score, counter and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      new_game_q  <= 1'b0;
      p1_q        <= 1'b0;
      p2_q        <= 1'b0;
      cnt_q       <= '0;
      p1_score_q  <= 8'h00;
      p2_score_q  <= 8'h00;
      serve_q     <= 1'b0;
      serve_dir_q <= 1'b0;
      game_over_q <= 1'b0;
      winner_q    <= 1'b0;
`ifdef SCORE_WIN_BLINK_EN
      phase_q       <= 1'b0;
      digit_blank_q <= 4'b0000;
`endif
    end else begin
      new_game_q  <= new_game;
      p1_q        <= point_p1;
      p2_q        <= point_p2;
      cnt_q       <= cnt_d;
      p1_score_q  <= p1_score_d;
      p2_score_q  <= p2_score_d;
      serve_q     <= serve_d;
      serve_dir_q <= serve_dir_d;
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
`ifdef SCORE_WIN_BLINK_EN
      phase_q       <= phase_d;
      digit_blank_q <= digit_blank_d;
`endif
    end
  end

  assign p1_tens   = p1_score_q[7:4];
  assign p1_ones   = p1_score_q[3:0];
  assign p2_tens   = p2_score_q[7:4];
  assign p2_ones   = p2_score_q[3:0];
  assign serve     = serve_q;
  assign serve_dir = serve_dir_q;
  assign game_over = game_over_q;
  assign winner    = winner_q;
`ifdef SCORE_WIN_BLINK_EN
  assign digit_blank = digit_blank_q;
`else
  assign digit_blank = 4'b0000;
`endif

endmodule

// File: tb/tb_pong_score_keeper.sv
// Directed bench for pong_score_keeper with SERVE_DELAY=4, BLINK_CYCLES=3, WIN_SCORE=11.
module tb_pong_score_keeper;

  logic       clk = 1'b0;
  logic       reset, new_game, point_p1, point_p2;
  logic [3:0] p1_tens, p1_ones, p2_tens, p2_ones, digit_blank;
  logic       serve, serve_dir, game_over, winner;
  int         vectors = 0;
  int         miscompares = 0;

  pong_score_keeper #(.WIN_SCORE(11), .SERVE_DELAY(4), .BLINK_CYCLES(3)) dut (
    .clk(clk), .reset(reset), .new_game(new_game), .point_p1(point_p1), .point_p2(point_p2),
    .p1_tens(p1_tens), .p1_ones(p1_ones), .p2_tens(p2_tens), .p2_ones(p2_ones),
    .serve(serve), .serve_dir(serve_dir), .game_over(game_over), .winner(winner),
    .digit_blank(digit_blank)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic score(input bit p2);
    if (p2) point_p2 = 1'b1; else point_p1 = 1'b1;
    tick(1);
    point_p1 = 1'b0;
    point_p2 = 1'b0;
  endtask

  task automatic wait_serve(input string tag);
    int n = 0;
    while (serve !== 1'b1 && n < 20) begin
      tick(1);
      n++;
    end
    vectors++;
    if (serve !== 1'b1) begin
      $display("FAIL %s serve timeout: serve=%b want 1", tag, serve);
      miscompares++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; new_game = 1'b0; point_p1 = 1'b0; point_p2 = 1'b0;
    tick(3);
    reset = 1'b0;
    vectors++;
    if ({p1_tens, p1_ones, p2_tens, p2_ones, serve, serve_dir, game_over, winner, digit_blank} !== 24'h000000) begin
      $display("FAIL reset_state: got %h%h-%h%h s=%b d=%b go=%b w=%b b=%b want all 0",
               p1_tens, p1_ones, p2_tens, p2_ones, serve, serve_dir, game_over, winner, digit_blank);
      miscompares++;
    end
  endtask

  task automatic test_serve_timing(input string tag);
    new_game = 1'b1;
    tick(1);
    new_game = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick(1);
      vectors++;
      if (serve !== (i == 4)) begin
        $display("FAIL %s serve cycle %0d: got %b want %b", tag, i, serve, (i == 4));
        miscompares++;
      end
    end
    vectors++;
    if ({p1_tens, p1_ones, p2_tens, p2_ones} !== 16'h0000) begin
      $display("FAIL %s digits: got %h want 0000", tag, {p1_tens, p1_ones, p2_tens, p2_ones});
      miscompares++;
    end
  endtask

  task automatic test_p1_win;
    for (int k = 1; k <= 11; k++) begin
      score(1'b0);
      vectors++;
      if ({p1_tens, p1_ones} !== {4'(k / 10), 4'(k % 10)} || serve_dir !== 1'b1) begin
        $display("FAIL p1_count %0d: got %h%h dir=%b want %0d%0d dir=1", k, p1_tens, p1_ones, serve_dir, k / 10, k % 10);
        miscompares++;
      end
      vectors++;
      if (game_over !== (k == 11)) begin
        $display("FAIL p1_game_over %0d: got %b want %b", k, game_over, (k == 11));
        miscompares++;
      end
      if (k < 11) wait_serve("p1_rally");
    end
    vectors++;
    if (winner !== 1'b0 || {p2_tens, p2_ones} !== 8'h00) begin
      $display("FAIL p1_winner: got w=%b p2=%h%h want w=0 p2=00", winner, p2_tens, p2_ones);
      miscompares++;
    end
    tick(6);
    vectors++;
    if (game_over !== 1'b1 || serve !== 1'b0 || {p1_tens, p1_ones} !== 8'h11) begin
      $display("FAIL p1_hold: got go=%b s=%b p1=%h%h want go=1 s=0 p1=11", game_over, serve, p1_tens, p1_ones);
      miscompares++;
    end
  endtask

  task automatic test_simultaneous;
    new_game = 1'b1;
    tick(1);
    new_game = 1'b0;
    vectors++;
    if (game_over !== 1'b0 || serve_dir !== 1'b0 || {p1_tens, p1_ones, p2_tens, p2_ones} !== 16'h0000) begin
      $display("FAIL restart: got go=%b d=%b %h want go=0 d=0 0000", game_over, serve_dir, {p1_tens, p1_ones, p2_tens, p2_ones});
      miscompares++;
    end
    wait_serve("restart");
    score(1'b0);
    wait_serve("sim_pre");
    point_p1 = 1'b1; point_p2 = 1'b1;
    tick(1);
    point_p1 = 1'b0; point_p2 = 1'b0;
    vectors++;
    if ({p1_tens, p1_ones, p2_tens, p2_ones} !== 16'h0100 || game_over !== 1'b0) begin
      $display("FAIL simultaneous: got %h go=%b want 0100 go=0", {p1_tens, p1_ones, p2_tens, p2_ones}, game_over);
      miscompares++;
    end
    for (int i = 0; i < 8; i++) begin
      tick(1);
      vectors++;
      if (serve !== 1'b0) begin
        $display("FAIL sim_no_serve %0d: got %b want 0", i, serve);
        miscompares++;
      end
    end
    score(1'b1);
    vectors++;
    if ({p2_tens, p2_ones} !== 8'h01 || serve_dir !== 1'b0) begin
      $display("FAIL sim_still_play: got p2=%h%h d=%b want 01 d=0", p2_tens, p2_ones, serve_dir);
      miscompares++;
    end
  endtask

  task automatic test_held_and_ignored;
    point_p1 = 1'b1;
    tick(1);
    point_p1 = 1'b0;
    vectors++;
    if ({p1_tens, p1_ones} !== 8'h01) begin
      $display("FAIL serve_wait_ignore: got %h%h want 01", p1_tens, p1_ones);
      miscompares++;
    end
    wait_serve("held_pre");
    point_p2 = 1'b1;
    tick(1);
    vectors++;
    if ({p2_tens, p2_ones} !== 8'h02) begin
      $display("FAIL held_first: got %h%h want 02", p2_tens, p2_ones);
      miscompares++;
    end
    tick(19);
    point_p2 = 1'b0;
    vectors++;
    if ({p1_tens, p1_ones, p2_tens, p2_ones} !== 16'h0102) begin
      $display("FAIL held_level: got %h want 0102", {p1_tens, p1_ones, p2_tens, p2_ones});
      miscompares++;
    end
    tick(1);
    new_game = 1'b1; point_p1 = 1'b1;
    tick(1);
    new_game = 1'b0; point_p1 = 1'b0;
    vectors++;
    if ({p1_tens, p1_ones, p2_tens, p2_ones} !== 16'h0000 || serve_dir !== 1'b0) begin
      $display("FAIL newgame_vs_point: got %h d=%b want 0000 d=0", {p1_tens, p1_ones, p2_tens, p2_ones}, serve_dir);
      miscompares++;
    end
    for (int i = 1; i <= 4; i++) begin
      tick(1);
      vectors++;
      if (serve !== (i == 4)) begin
        $display("FAIL newgame_serve %0d: got %b want %b", i, serve, (i == 4));
        miscompares++;
      end
    end
  endtask

  task automatic test_reset_mid_wait;
    score(1'b1);
    wait_serve("rst_pre");
    score(1'b0);
    vectors++;
    if ({p1_tens, p1_ones, p2_tens, p2_ones} !== 16'h0101 || serve_dir !== 1'b1) begin
      $display("FAIL rst_setup: got %h d=%b want 0101 d=1", {p1_tens, p1_ones, p2_tens, p2_ones}, serve_dir);
      miscompares++;
    end
    tick(2);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    vectors++;
    if ({p1_tens, p1_ones, p2_tens, p2_ones, serve, serve_dir, game_over, winner, digit_blank} !== 24'h000000) begin
      $display("FAIL reset_mid_wait: got %h s=%b d=%b go=%b w=%b b=%b want all 0",
               {p1_tens, p1_ones, p2_tens, p2_ones}, serve, serve_dir, game_over, winner, digit_blank);
      miscompares++;
    end
    for (int i = 0; i < 8; i++) begin
      tick(1);
      vectors++;
      if (serve !== 1'b0) begin
        $display("FAIL idle_no_serve %0d: got %b want 0", i, serve);
        miscompares++;
      end
    end
    score(1'b0);
    vectors++;
    if ({p1_tens, p1_ones} !== 8'h00) begin
      $display("FAIL idle_ignore: got %h%h want 00", p1_tens, p1_ones);
      miscompares++;
    end
    tick(1);
    test_serve_timing("after_reset");
  endtask

  task automatic test_p2_win_blink;
    logic [3:0] exp_b;
    for (int k = 1; k <= 11; k++) begin
      score(1'b1);
      if (k < 11) wait_serve("p2_rally");
    end
    vectors++;
    if ({p1_tens, p1_ones, p2_tens, p2_ones} !== 16'h0011 || game_over !== 1'b1 || winner !== 1'b1) begin
      $display("FAIL p2_win: got %h go=%b w=%b want 0011 go=1 w=1", {p1_tens, p1_ones, p2_tens, p2_ones}, game_over, winner);
      miscompares++;
    end
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) tick(1);
`ifdef SCORE_WIN_BLINK_EN
      exp_b = (i >= 3 && i <= 5) ? 4'b0011 : 4'b0000;
`else
      exp_b = 4'b0000;
`endif
      vectors++;
      if (digit_blank !== exp_b) begin
        $display("FAIL blink %0d: got %b want %b", i, digit_blank, exp_b);
        miscompares++;
      end
    end
    tick(2);
    new_game = 1'b1;
    tick(1);
    new_game = 1'b0;
    vectors++;
    if (digit_blank !== 4'b0000 || game_over !== 1'b0 || {p2_tens, p2_ones} !== 8'h00) begin
      $display("FAIL blink_clear: got b=%b go=%b p2=%h%h want 0000 0 00", digit_blank, game_over, p2_tens, p2_ones);
      miscompares++;
    end
  endtask

  initial begin
    test_reset();
    test_serve_timing("first_serve");
    test_p1_win();
    test_simultaneous();
    test_held_and_ignored();
    test_reset_mid_wait();
    test_p2_win_blink();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
